// File: rtl/gearbox_narrow_to_wide_if.sv
// Handshake bundle for gearbox_narrow_to_wide: valid/ready input side of
// IN_W-bit words and valid/ready output side of OUT_W-bit words.
// The master modport is the stream producer/consumer environment and the slave
// modport is the gearbox itself.
interface gearbox_narrow_to_wide_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 33
) ();
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gearbox_narrow_to_wide.sv
// Narrow-to-wide streaming gearbox. It packs a continuous bit stream of IN_W-bit
// words into OUT_W-bit words through a bit buffer. The LSB of the buffer holds the
// oldest bit. The output side is Moore. The only combinational path runs from
// out_ready to in_ready.
// Optional macro GEARBOX_FLUSH_EN adds the flush input and the out_pad output.
// These emit a residual partial word, zero-extended.
module gearbox_narrow_to_wide #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 33
) (
  input  logic                              clk,
  input  logic                              rst_n,
  gearbox_narrow_to_wide_if.slave           bus,
  output logic [$clog2(OUT_W+IN_W)-1:0]     fill
`ifdef GEARBOX_FLUSH_EN
  ,
  input  logic                              flush,
  output logic [$clog2(OUT_W+1)-1:0]        out_pad
`endif
);

  localparam int BUF_W  = OUT_W + IN_W - 1;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] IN_W_F  = FILL_W'(IN_W);
  localparam logic [FILL_W-1:0] BUF_W_F = FILL_W'(BUF_W);

  if (!((IN_W < OUT_W) && (OUT_W <= 2 * IN_W))) begin : g_bad_widths
    $error("gearbox_narrow_to_wide: need IN_W < OUT_W <= 2*IN_W");
  end

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [BUF_W-1:0]  push_mask, push_bits;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              word_rdy;
  logic              out_valid;
  logic              pop;
  logic              push;
  logic              in_ready;
  logic              flushing;

`ifdef GEARBOX_FLUSH_EN
  logic flushing_q, flushing_d;
  assign flushing = flushing_q;
`else
  assign flushing = 1'b0;
`endif

  assign word_rdy  = (fill_q >= OUT_W_F);
  assign out_valid = word_rdy || flushing;
  assign pop       = out_valid && bus.out_ready;
  assign in_ready  = rst_n && !flushing && (!word_rdy || pop);
  assign push      = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign fill          = fill_q;

`ifdef GEARBOX_FLUSH_EN
  // A flushed word exposes only the fill_q valid bits, zero-extended.
  assign bus.out_data = flushing ? (buf_q[OUT_W-1:0] & ~({OUT_W{1'b1}} << fill_q))
                                 : buf_q[OUT_W-1:0];
  assign out_pad      = flushing ? ($clog2(OUT_W+1))'(OUT_W_F - fill_q) : '0;
`else
  assign bus.out_data = buf_q[OUT_W-1:0];
`endif

  // Next buffer/fill: retire the output word first, then append the new input word
  // above the remaining bits.
  always_comb begin
    buf_d  = buf_q;
    fill_d = fill_q;
    if (pop) begin
      if (flushing) begin
        buf_d  = '0;
        fill_d = '0;
      end else begin
        buf_d  = buf_q >> OUT_W;
        fill_d = fill_q - OUT_W_F;
      end
    end
    push_mask = BUF_W'({IN_W{1'b1}}) << fill_d;
    push_bits = BUF_W'(bus.in_data) << fill_d;
    if (push) begin
      buf_d  = (buf_d & ~push_mask) | push_bits;
      fill_d = fill_d + IN_W_F;
    end
  end

`ifdef GEARBOX_FLUSH_EN
  // Flushing flag: set by a flush request on an idle partial buffer, cleared by the pop.
  always_comb begin
    flushing_d = flushing_q;
    if (flushing_q) begin
      if (pop) flushing_d = 1'b0;
    end else if (flush && !push && (fill_q != '0) && !word_rdy) begin
      flushing_d = 1'b1;
    end
  end

  // Flushing flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) flushing_q <= 1'b0;
    else        flushing_q <= flushing_d;
  end
`endif

  // Buffer and fill registers; reset discards any partial bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  a_fill_bound: assert property (@(posedge clk) disable iff (!rst_n) fill_q <= BUF_W_F)
    else $error("gearbox_narrow_to_wide: fill exceeds buffer capacity");

endmodule

// File: tb/tb_gearbox_narrow_to_wide.sv
// Self-checking bench for gearbox_narrow_to_wide using a bit-queue reference model.
module tb_gearbox_narrow_to_wide;
  localparam int IN_W   = 32;
  localparam int OUT_W  = 33;
  localparam int BUF_W  = OUT_W + IN_W - 1;
  localparam int FILL_W = $clog2(OUT_W + IN_W);

  logic clk = 1'b0;
  logic rst_n;
  logic [FILL_W-1:0] fill;
`ifdef GEARBOX_FLUSH_EN
  logic flush;
  logic [$clog2(OUT_W+1)-1:0] out_pad;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit mq[$];

  gearbox_narrow_to_wide_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  gearbox_narrow_to_wide #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .fill  (fill)
`ifdef GEARBOX_FLUSH_EN
    ,
    .flush   (flush),
    .out_pad (out_pad)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef GEARBOX_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    mq.delete();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.in_data = $urandom;
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      n_checks++;
      if (fill !== '0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill); end
      n_checks++;
      if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    mq.delete();
    tick();
  endtask

  task automatic test_ordering();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0;
    tick();
    bus.in_data   = 32'h1;
    tick();
    bus.in_valid  = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL order_valid: got %b expected 1", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 33'h1_0000_0000) begin n_fail++; $display("FAIL order_data: got %h expected 100000000", bus.out_data); end
    tick();
    n_checks++;
    if (fill !== FILL_W'(31)) begin n_fail++; $display("FAIL order_fill: got %0d expected 31", fill); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL order_valid_after: got %b expected 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  // mode: 0 all ones, 1 incrementing, 2 random. rand_hs randomises in_valid/out_ready.
  // out_ready is held low for the first 'hold' cycles.
  task automatic test_stream(input string name, input int nwords, input int mode,
                             input bit rand_hs, input int hold, input bit expect_no_stall,
                             output int max_fill);
    int acc = 0, outs = 0, cyc = 0, stalls = 0, s0;
    bit exp_ov, exp_ir;
    logic [IN_W-1:0]  d;
    logic [OUT_W-1:0] e;
    s0 = mq.size();
    max_fill = 0;
    while ((acc < nwords || mq.size() >= OUT_W) && cyc < 3000) begin
      bus.in_valid = (acc < nwords) && (rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1);
      case (mode)
        0:       d = '1;
        1:       d = IN_W'(acc) + 32'h0000_0100;
        default: d = $urandom;
      endcase
      bus.in_data   = d;
      bus.out_ready = (cyc < hold) ? 1'b0 : (rand_hs ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk);
      if (int'(fill) > max_fill) max_fill = int'(fill);
      exp_ov = (mq.size() >= OUT_W);
      exp_ir = !exp_ov || bus.out_ready;
      n_checks++;
      if (fill !== FILL_W'(mq.size())) begin n_fail++; $display("FAIL %s_fill: got %0d expected %0d", name, fill, mq.size()); end
      n_checks++;
      if (bus.out_valid !== exp_ov) begin n_fail++; $display("FAIL %s_out_valid: got %b expected %b", name, bus.out_valid, exp_ov); end
      n_checks++;
      if (bus.in_ready !== exp_ir) begin n_fail++; $display("FAIL %s_in_ready: got %b expected %b", name, bus.in_ready, exp_ir); end
`ifdef GEARBOX_FLUSH_EN
      n_checks++;
      if (out_pad !== '0) begin n_fail++; $display("FAIL %s_out_pad: got %0d expected 0", name, out_pad); end
`endif
      if (exp_ov) begin
        for (int i = 0; i < OUT_W; i++) e[i] = mq[i];
        n_checks++;
        if (bus.out_data !== e) begin n_fail++; $display("FAIL %s_out_data: got %h expected %h", name, bus.out_data, e); end
      end
      if (bus.in_valid && !bus.in_ready) stalls++;
      if (exp_ov && bus.out_ready) begin
        for (int i = 0; i < OUT_W; i++) void'(mq.pop_front());
        outs++;
      end
      if (bus.in_valid && exp_ir) begin
        for (int i = 0; i < IN_W; i++) mq.push_back(d[i]);
        acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (cyc >= 3000) begin n_fail++; $display("FAIL %s_timeout: got %0d cycles expected fewer than 3000", name, cyc); end
    n_checks++;
    if (outs != (s0 + nwords * IN_W) / OUT_W) begin
      n_fail++; $display("FAIL %s_outputs: got %0d expected %0d", name, outs, (s0 + nwords * IN_W) / OUT_W);
    end
    n_checks++;
    if (fill !== FILL_W'(mq.size())) begin n_fail++; $display("FAIL %s_final_fill: got %0d expected %0d", name, fill, mq.size()); end
    if (expect_no_stall) begin
      n_checks++;
      if (stalls != 0) begin n_fail++; $display("FAIL %s_stalls: got %0d expected 0", name, stalls); end
    end
  endtask

  task automatic test_full_cycle();
    int mf;
    do_reset();
    test_stream("full_ones", 33, 0, 1'b0, 0, 1'b1, mf);
    n_checks++;
    if (fill !== '0) begin n_fail++; $display("FAIL full_ones_empty: got %0d expected 0", fill); end
    do_reset();
    test_stream("full_inc", 33, 1, 1'b0, 0, 1'b1, mf);
    n_checks++;
    if (fill !== '0) begin n_fail++; $display("FAIL full_inc_empty: got %0d expected 0", fill); end
    test_stream("back_to_back", 66, 2, 1'b0, 0, 1'b1, mf);
  endtask

  task automatic test_backpressure();
    int mf;
    do_reset();
    test_stream("backpressure", 12, 2, 1'b0, 8, 1'b0, mf);
    n_checks++;
    if (mf != 2 * IN_W) begin n_fail++; $display("FAIL backpressure_max_fill: got %0d expected %0d", mf, 2 * IN_W); end
    n_checks++;
    if (mf > BUF_W) begin n_fail++; $display("FAIL backpressure_bound: got %0d expected <= %0d", mf, BUF_W); end
  endtask

  task automatic test_random();
    int mf;
    do_reset();
    test_stream("random", 150, 2, 1'b1, 0, 1'b0, mf);
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = $urandom;
      tick();
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (fill !== '0) begin n_fail++; $display("FAIL midrst_fill: got %0d expected 0", fill); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 0", bus.in_ready); end
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_data = 32'hA5A5_A5A5;
    tick();
    bus.in_data = 32'h0;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_new_valid: got %b expected 1", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 33'h0_A5A5_A5A5) begin n_fail++; $display("FAIL midrst_new_data: got %h expected 0a5a5a5a5", bus.out_data); end
  endtask

`ifdef GEARBOX_FLUSH_EN
  task automatic test_flush();
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1234_5678;
    tick();
    bus.in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b expected 1", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 33'h0_1234_5678) begin n_fail++; $display("FAIL flush_data: got %h expected 012345678", bus.out_data); end
    n_checks++;
    if (out_pad !== 1) begin n_fail++; $display("FAIL flush_pad: got %0d expected 1", out_pad); end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (fill !== '0) begin n_fail++; $display("FAIL flush_fill_after: got %0d expected 0", fill); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b expected 1", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_after: got %b expected 0", bus.out_valid); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef GEARBOX_FLUSH_EN
    flush = 1'b0;
`endif
    test_reset();
    test_ordering();
    test_full_cycle();
    test_backpressure();
    test_random();
    test_mid_reset();
`ifdef GEARBOX_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
